// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings for the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2,
        ARB_HALT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// rtl/bus_rr_pick.sv - combinational rotate-priority encoder, scanning from last+1
module bus_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] pick,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        logic [IW-1:0] cand;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between N masters
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_read_q,
    input  logic [N_REQ-1:0]           req_write_q,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_read_dn,
    output logic [N_REQ-1:0]           req_write_dn,
    output logic [DATA_W-1:0]          req_data_out,
    output logic [N_REQ-1:0]           bus_busy,
    output logic [N_REQ-1:0]           grant,
    output logic                       mem_read_q,
    output logic                       mem_write_q,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_out,
    input  logic [DATA_W-1:0]          mem_data_in,
    input  logic                       mem_read_dn,
    input  logic                       mem_write_dn,
    input  logic                       halt_q,
    output logic                       halt_ack,
    output logic                       timeout_err,
    output logic [$clog2(N_REQ)-1:0]   err_id
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state, state_nx;
    logic [IW-1:0]    last, gidx, pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_any;
    logic             is_write;
    logic [TO_W-1:0]  to_cnt;
    logic             wait_dn, wait_to;

    bus_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req  (req_read_q | req_write_q),
        .last (last),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign wait_dn  = is_write ? mem_write_dn : mem_read_dn;
    assign wait_to  = (to_cnt == TO_W'(TIMEOUT - 1));
    assign bus_busy = (state == ARB_HALT) ? '1 : ((|grant) ? ~grant : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARB_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE: begin
                if (halt_q)        state_nx = ARB_HALT;
                else if (pick_any) state_nx = ARB_WAIT;
            end
            ARB_WAIT: if (wait_dn || wait_to) state_nx = ARB_DONE;
            ARB_DONE: state_nx = ARB_IDLE;
            ARB_HALT: if (!halt_q) state_nx = ARB_IDLE;
            default:  state_nx = ARB_IDLE;
        endcase
    end

    // Completion pulses, error flag and read data are single-cycle: cleared unless re-set below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last         <= IW'(N_REQ - 1);
            gidx         <= '0;
            grant        <= '0;
            is_write     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            to_cnt       <= '0;
            req_read_dn  <= '0;
            req_write_dn <= '0;
            req_data_out <= '0;
            halt_ack     <= 1'b0;
            timeout_err  <= 1'b0;
            err_id       <= '0;
        end else begin
            req_read_dn  <= '0;
            req_write_dn <= '0;
            req_data_out <= '0;
            timeout_err  <= 1'b0;
            halt_ack     <= (state_nx == ARB_HALT);
            case (state)
                ARB_IDLE: begin
                    if (!halt_q && pick_any) begin
                        grant        <= pick_oh;
                        gidx         <= pick_idx;
                        mem_addr     <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_data_out <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        is_write     <= req_write_q[pick_idx];
                        mem_write_q  <= req_write_q[pick_idx];
                        mem_read_q   <= ~req_write_q[pick_idx];
                        to_cnt       <= '0;
                    end
                end
                ARB_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (wait_dn || wait_to) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (is_write) req_write_dn[gidx] <= 1'b1;
                        else          req_read_dn[gidx]  <= 1'b1;
                        if (wait_dn) begin
                            req_data_out <= is_write ? '0 : mem_data_in;
                        end else begin
                            timeout_err <= 1'b1;
                            err_id      <= gidx;
                        end
                    end
                end
                ARB_DONE: begin
                    last  <= gidx;
                    grant <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
